// File: rtl/uart_rx_if.sv
// Receive-side byte stream of the UART: single-entry valid/ready byte output
// plus the one-cycle framing-error and overrun status pulses.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
   modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// single-entry holding register with framing-error and overrun pulses.
module uart_rx #(
   parameter int CLOCK_HZ = 27_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic    sys_clk,
   input  logic    rst,
   input  logic    rx_pin,
   uart_rx_if.master rx
);
   localparam int DIV  = CLOCK_HZ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   generate
      if (DIV < 16) begin : g_div_chk
         $error("uart_rx: CLOCK_HZ/BAUD must be at least 16");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t        state_q, state_d;
   logic          s1, rx_s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          tick, deliver, accept;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         s1      <= 1'b1;
         rx_s    <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         s1      <= rx_pin;
         rx_s    <= s1;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign tick   = (cnt_q == '0);
   assign accept = valid_q & rx.rx_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
      idx_d   = idx_q;
      sh_d    = sh_q;
      deliver = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               cnt_d   = CW'(HALF - 1);
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (!rx_s) begin
                  cnt_d   = CW'(DIV - 1);
                  idx_d   = '0;
                  state_d = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               sh_d  = {rx_s, sh_q[7:1]};
               cnt_d = CW'(DIV - 1);
               if (idx_q == 3'd7) state_d = S_STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (rx_s) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // a held-low line must go high before another start is looked for
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // consuming and delivering in the same cycle leaves no bubble
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q & ~accept;
      ovr_d   = 1'b0;
      if (deliver) begin
         if (!valid_q || accept) begin
            data_d  = sh_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign rx.rx_data   = data_q;
   assign rx.rx_valid  = valid_q;
   assign rx.frame_err = ferr_q;
   assign rx.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames
// against a byte-level reference (expected byte queue and error counts).
module tb_uart_rx;
   localparam int CLOCK_HZ = 27_000_000;
   localparam int BAUD     = 115_200;
   localparam int DIV      = CLOCK_HZ / BAUD;
   localparam int HALF     = DIV / 2;

   logic sys_clk = 1'b0;
   logic rst     = 1'b1;
   logic rx_pin  = 1'b1;

   uart_rx_if rif();

   uart_rx #(.CLOCK_HZ(CLOCK_HZ), .BAUD(BAUD)) dut (
      .sys_clk(sys_clk),
      .rst    (rst),
      .rx_pin (rx_pin),
      .rx     (rif)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // observed activity, sampled mid-cycle
   logic [7:0] got_q[$];
   int         rise_q[$];
   int         fe_cnt = 0, ov_cnt = 0, both_cnt = 0, stab_cnt = 0, vcyc = 0;
   logic       pv = 1'b0, phs = 1'b0;
   logic [7:0] pd = '0;

   always @(negedge sys_clk) begin
      #1;
      if (rst) begin
         pv  = 1'b0;
         phs = 1'b0;
      end else begin
         if (rif.rx_valid && !pv) rise_q.push_back(cyc);
         if (rif.rx_valid) vcyc++;
         if (rif.rx_valid && rif.rx_ready) got_q.push_back(rif.rx_data);
         if (rif.frame_err) fe_cnt++;
         if (rif.overrun) ov_cnt++;
         if (rif.frame_err && rif.overrun) both_cnt++;
         if (pv && !phs && rif.rx_data !== pd) stab_cnt++;
         pv  = rif.rx_valid;
         phs = rif.rx_valid && rif.rx_ready;
         pd  = rif.rx_data;
      end
   end

   initial begin
      #(2_000_000 * 10);
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic drive_bit(input logic v);
      rx_pin = v;
      repeat (DIV) @(negedge sys_clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rif.rx_ready = 1'b1;
      repeat (3) @(negedge sys_clk);
      checks++; if (rif.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rif.rx_valid); end
      checks++; if (rif.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rif.rx_data); end
      checks++; if (rif.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", rif.frame_err); end
      checks++; if (rif.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", rif.overrun); end
      rst = 1'b0;
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic test_single();
      int n0, r0, v0, f0, o0, c0, lo, hi;
      n0 = got_q.size(); r0 = rise_q.size(); v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
      rif.rx_ready = 1'b1;
      c0 = cyc;
      send_byte(8'hA5, 1'b1);
      repeat (4) @(negedge sys_clk);
      // first edge seeing the low line is c0+1; valid lands 3+HALF+9*DIV +-1 later
      lo = c0 + 1 + 2 + HALF + 9 * DIV;
      hi = c0 + 1 + 4 + HALF + 9 * DIV;
      checks++;
      if (got_q.size() != n0 + 1) begin
         errors++; $display("FAIL single_count got %0d exp %0d", got_q.size() - n0, 1);
      end else if (got_q[n0] !== 8'hA5) begin
         errors++; $display("FAIL single_data got %h exp a5", got_q[n0]);
      end
      checks++;
      if (rise_q.size() != r0 + 1 || rise_q[r0] < lo || rise_q[r0] > hi) begin
         errors++;
         $display("FAIL single_latency got %0d exp %0d..%0d",
                  (rise_q.size() > r0) ? rise_q[r0] - c0 - 1 : -1, lo - c0 - 1, hi - c0 - 1);
      end
      checks++; if (vcyc - v0 != 1) begin errors++; $display("FAIL single_valid_width got %0d exp 1", vcyc - v0); end
      checks++;
      if (fe_cnt != f0 || ov_cnt != o0) begin
         errors++; $display("FAIL single_no_err got fe=%0d ov=%0d exp 0 0", fe_cnt - f0, ov_cnt - o0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [3];
      int n0, r0;
      vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h55;
      n0 = got_q.size(); r0 = rise_q.size();
      rif.rx_ready = 1'b1;
      for (int k = 0; k < 3; k++) send_byte(vals[k], 1'b1);
      repeat (4) @(negedge sys_clk);
      checks++;
      if (got_q.size() != n0 + 3) begin
         errors++; $display("FAIL b2b_count got %0d exp 3", got_q.size() - n0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_q[n0 + k] !== vals[k]) begin
               errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k, got_q[n0 + k], vals[k]);
            end
         end
      end
      if (rise_q.size() == r0 + 3) begin
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (rise_q[r0 + k] - rise_q[r0 + k - 1] != 10 * DIV) begin
               errors++; $display("FAIL b2b_spacing[%0d] got %0d exp %0d", k,
                                  rise_q[r0 + k] - rise_q[r0 + k - 1], 10 * DIV);
            end
         end
      end else begin
         checks++; errors++;
         $display("FAIL b2b_rises got %0d exp 3", rise_q.size() - r0);
      end
   endtask

   task automatic test_overrun();
      int n0, o0, f0;
      n0 = got_q.size(); o0 = ov_cnt; f0 = fe_cnt;
      rif.rx_ready = 1'b0;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (4) @(negedge sys_clk);
      checks++; if (rif.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", rif.rx_valid); end
      checks++; if (rif.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h exp 11", rif.rx_data); end
      checks++; if (ov_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ov_cnt - o0); end
      checks++; if (fe_cnt != f0) begin errors++; $display("FAIL ovr_ferr got %0d exp 0", fe_cnt - f0); end
      rif.rx_ready = 1'b1;
      repeat (2) @(negedge sys_clk);
      checks++;
      if (got_q.size() != n0 + 1 || got_q[got_q.size() - 1] !== 8'h11) begin
         errors++; $display("FAIL ovr_accept got count %0d exp 1 with byte 11", got_q.size() - n0);
      end
      checks++; if (rif.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", rif.rx_valid); end
   endtask

   task automatic test_framing();
      int n0, f0, v0;
      n0 = got_q.size(); f0 = fe_cnt; v0 = vcyc;
      rif.rx_ready = 1'b1;
      send_byte(8'h3C, 1'b0);
      repeat (20 * DIV) @(negedge sys_clk);
      rx_pin = 1'b1;
      repeat (2 * DIV) @(negedge sys_clk);
      checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL frame_err_pulses got %0d exp 1", fe_cnt - f0); end
      checks++; if (vcyc != v0) begin errors++; $display("FAIL frame_no_valid got %0d cycles exp 0", vcyc - v0); end
      send_byte(8'h7E, 1'b1);
      repeat (4) @(negedge sys_clk);
      checks++;
      if (got_q.size() != n0 + 1 || got_q[got_q.size() - 1] !== 8'h7E) begin
         errors++; $display("FAIL frame_recover got count %0d exp 1 with byte 7e", got_q.size() - n0);
      end
   endtask

   task automatic test_glitch();
      int n0, f0;
      n0 = got_q.size(); f0 = fe_cnt;
      rx_pin = 1'b0;
      repeat (50) @(negedge sys_clk);
      rx_pin = 1'b1;
      repeat (2 * DIV) @(negedge sys_clk);
      checks++;
      if (got_q.size() != n0 || fe_cnt != f0) begin
         errors++; $display("FAIL glitch_reject got bytes=%0d fe=%0d exp 0 0", got_q.size() - n0, fe_cnt - f0);
      end
      send_byte(8'h81, 1'b1);
      repeat (4) @(negedge sys_clk);
      checks++;
      if (got_q.size() != n0 + 1 || got_q[got_q.size() - 1] !== 8'h81) begin
         errors++; $display("FAIL glitch_recover got count %0d exp 1 with byte 81", got_q.size() - n0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      int n0;
      v = 8'hF0;
      n0 = got_q.size();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(v[i]);
      rx_pin = v[4];
      rst = 1'b1;
      @(negedge sys_clk);
      rst = 1'b0;
      checks++; if (rif.rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", rif.rx_data); end
      checks++;
      if (rif.rx_valid !== 1'b0 || rif.frame_err !== 1'b0 || rif.overrun !== 1'b0) begin
         errors++; $display("FAIL rstmid_flags got v=%b fe=%b ov=%b exp 0 0 0",
                            rif.rx_valid, rif.frame_err, rif.overrun);
      end
      repeat (DIV - 1) @(negedge sys_clk);
      for (int i = 5; i < 8; i++) drive_bit(v[i]);
      drive_bit(1'b1);
      repeat (DIV) @(negedge sys_clk);
      checks++; if (got_q.size() != n0) begin errors++; $display("FAIL rstmid_dropped got %0d bytes exp 0", got_q.size() - n0); end
      send_byte(8'h0F, 1'b1);
      repeat (4) @(negedge sys_clk);
      checks++;
      if (got_q.size() != n0 + 1 || got_q[got_q.size() - 1] !== 8'h0F) begin
         errors++; $display("FAIL rstmid_recover got count %0d exp 1 with byte 0f", got_q.size() - n0);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      int n0, f0, o0, fe_exp;
      logic done;
      n0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt; fe_exp = 0; done = 1'b0;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               logic [7:0] b;
               logic bad;
               b   = 8'($urandom);
               bad = ($urandom_range(0, 4) == 0);
               send_byte(b, !bad);
               if (bad) begin
                  fe_exp++;
                  rx_pin = 1'b1;
                  repeat (DIV + $urandom_range(0, DIV)) @(negedge sys_clk);
               end else begin
                  exp_q.push_back(b);
                  repeat ($urandom_range(0, DIV)) @(negedge sys_clk);
               end
            end
            repeat (4) @(negedge sys_clk);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge sys_clk);
               rif.rx_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      rif.rx_ready = 1'b1;
      repeat (4) @(negedge sys_clk);
      checks++;
      if (got_q.size() - n0 != exp_q.size()) begin
         errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size() - n0, exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (got_q[n0 + k] !== exp_q[k]) begin
               errors++; $display("FAIL rand_data[%0d] got %h exp %h", k, got_q[n0 + k], exp_q[k]);
            end
         end
      end
      checks++; if (fe_cnt - f0 != fe_exp) begin errors++; $display("FAIL rand_ferr got %0d exp %0d", fe_cnt - f0, fe_exp); end
      checks++; if (ov_cnt != o0) begin errors++; $display("FAIL rand_ovr got %0d exp 0", ov_cnt - o0); end
   endtask

   task automatic test_invariants();
      checks++; if (stab_cnt != 0) begin errors++; $display("FAIL data_stable got %0d changes exp 0", stab_cnt); end
      checks++; if (both_cnt != 0) begin errors++; $display("FAIL pulse_exclusive got %0d exp 0", both_cnt); end
   endtask

   initial begin
      rif.rx_ready = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_framing();
      test_glitch();
      test_reset_mid();
      test_random();
      test_invariants();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver for the Tang Nano 20K SoC, the receive counterpart to the SoC's UART transmitter. It synchronises the asynchronous `rx_pin` into `sys_clk`, detects start bits, samples each bit at mid-period, and presents received bytes on a single-entry valid/ready output. Framing errors and overruns are reported as one-cycle pulses for a status register or an interrupt.

## Interface
- `CLOCK_HZ`, default 27_000_000: frequency of `sys_clk` in Hz.
- `BAUD`, default 115_200: line rate in bit/s.
- Derived localparams:
  - `DIV = CLOCK_HZ / BAUD` (integer division), 234 at the defaults.
  - `HALF = DIV / 2`, 117 at the defaults.
  - Elaboration fails if `DIV < 16`.

- `sys_clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_pin`  in  1  asynchronous serial input. The line idles high.
- `rx_data`  out  8  received byte. Stable while `rx_valid` is high.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts `rx_data` in any cycle where `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a completed byte was dropped because the holding register was full.

## Operation
- **Synchroniser:** two flops, `rx_pin` -> `s1` -> `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Bit-period counter `cnt`:** counts down; width is `$clog2(DIV)`. A sample event occurs when `cnt == 0`.
- **Bit index `idx`:** 3 bits, counts data bits 0..7.
- **Shift register `sh`:** 8 bits. Bits arrive LSB first; each sample shifts `rx_s` in at bit 7.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** when `rx_s == 0`, load `cnt <= HALF-1` and go to START.
  - **START:** at `cnt == 0`:
    - `rx_s == 0`: load `cnt <= DIV-1` and `idx <= 0`, go to DATA.
    - `rx_s == 1`: false start (glitch). Return to IDLE with no output.
  - **DATA:** at `cnt == 0`:
    - Shift `rx_s` into `sh` and load `cnt <= DIV-1`.
    - `idx == 7`: go to STOP. Otherwise increment `idx`.
  - **STOP:** at `cnt == 0`:
    - `rx_s == 1`: deliver `sh` (see below), go to IDLE.
    - `rx_s == 0`: pulse `frame_err` for one cycle, discard `sh`, go to BREAK.
  - **BREAK:** wait for `rx_s == 1`, then go to IDLE. A held-low line (break) produces exactly one `frame_err` and no bytes.
- **Delivery (the cycle STOP samples a valid stop bit):**
  - If `!rx_valid`, or `rx_valid & rx_ready` in that same cycle: `rx_data <= sh` and `rx_valid <= 1`. The old byte is consumed and the new byte is loaded with no gap.
  - Otherwise: pulse `overrun` for one cycle and drop the new byte. `rx_data` and `rx_valid` are unchanged.
- **Handshake:**
  - When `rx_valid & rx_ready` with no simultaneous delivery, `rx_valid` falls on the next edge.
  - `rx_data` changes only on a delivery.
  - `rx_ready` has no effect while `rx_valid` is low.
- **Reset:**
  - Applies from any state, including mid-byte. The partial byte is discarded.
  - Reset values: FSM = IDLE, `cnt = 0`, `idx = 0`, `sh = 0`, `rx_data = 0`, `rx_valid = 0`, `frame_err = 0`, `overrun = 0`, synchroniser flops = 1.
  - After `rst` is released, a line that is already low is treated as a start bit once `rx_s` goes low.

## Timing
- All outputs are registered. There are no combinational paths from `rx_pin` or `rx_ready` to any output.
- **Start latency:** the synchroniser adds 2 cycles. The FSM leaves IDLE on the edge after `rx_s` first reads 0.
- **Sample points:**
  - Start bit is sampled HALF cycles after leaving IDLE.
  - Each data bit and the stop bit are sampled DIV cycles after the previous sample.
- **Output latency:** `rx_valid` rises `3 + HALF + 9*DIV` cycles (±1) after the first `sys_clk` edge that samples `rx_pin` low. At the defaults this is 2226 ± 1 cycles.
- **Back-to-back frames:**
  - The receiver is in IDLE one cycle after the stop-bit sample, roughly half a bit before the stop bit ends.
  - A start bit immediately following a stop bit is therefore detected with no frame loss.
- **Clock tolerance:** up to ±2 % combined baud mismatch with `DIV >= 16`.
- **Pulse widths:** `frame_err` and `overrun` are high for exactly one cycle per event and never in the same cycle.

## Test plan
- **Single byte:** drive 0xA5 at 115200 baud (234 clocks/bit), `rx_ready = 1`.
  - Expect `rx_data = 0xA5` and `rx_valid` high for exactly 1 cycle, 2226 ± 1 cycles after the start edge.
  - Expect no error pulses.
- **Back-to-back:** send 0x00, 0xFF, 0x55 with no idle gap, `rx_ready = 1`.
  - Expect three valid beats with data 0x00, 0xFF, 0x55, spaced 2340 cycles apart.
- **Overrun:** hold `rx_ready = 0`, send 0x11 then 0x22.
  - Expect `rx_data` to stay 0x11 with `rx_valid` high.
  - Expect one `overrun` pulse at the 0x22 stop sample.
  - Raise `rx_ready`: 0x11 is accepted, then `rx_valid` drops.
- **Framing error / break:**
  - Send 0x3C with the stop bit low, then hold the line low for 20 bit times.
  - Expect exactly one `frame_err` pulse and no `rx_valid`.
  - Then release the line and send 0x7E: expect `rx_data = 0x7E`.
- **Glitch rejection:** drive `rx_pin` low for 50 cycles (< HALF), then high.
  - Expect no `rx_valid` and no `frame_err`.
  - A following 0x81 is received correctly.
- **Reset mid-byte:** assert `rst` for 1 cycle after the 4th data bit of 0xF0.
  - Expect all outputs at their reset values and no byte delivered for that frame.
  - A following 0x0F is received correctly.
